// File: rtl/ser_des_pkg.sv
// Shared definitions for the serial link: frame constants, receiver FSM states
// and the even-parity helper used by both serializer and receiver.
package ser_des_pkg;

  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 11;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead byte FIFO; a push onto a full FIFO only succeeds when a pop
// happens in the same cycle.
module rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ser_frame_rx.sv
// Framed serial receiver: start / 8 data LSB first / even parity / stop,
// good bytes buffered in rx_fifo behind a valid/ready interface.
module ser_frame_rx
  import ser_des_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       ser_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad;
  logic                 bit_tick;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign bit_tick  = (cnt == BIT_LAST);
  // Push is decoded on the stop-sample edge itself so the FIFO registers it there.
  assign push      = (state == STOP) && bit_tick && (ser_in == IDLE_LEVEL) && !par_bad;
  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      cnt        <= cnt + CNT_W'(1);
      unique case (state)
        IDLE: if (ser_in != IDLE_LEVEL) begin
          state   <= START;
          cnt     <= '0;
          bit_idx <= '0;
        end
        START: if (cnt == HALF_LAST) begin
          cnt   <= '0;
          state <= (ser_in == IDLE_LEVEL) ? IDLE : DATA;
        end
        DATA: if (bit_tick) begin
          cnt     <= '0;
          shift   <= {ser_in, shift[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'(DATA_BITS - 1)) state <= PARITY;
        end
        PARITY: if (bit_tick) begin
          cnt     <= '0;
          par_bad <= parity(shift) ^ ser_in;
          state   <= STOP;
        end
        STOP: if (bit_tick) begin
          cnt <= '0;
          if (ser_in == IDLE_LEVEL) begin
            parity_err <= par_bad;
            state      <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= BREAK;
          end
        end
        BREAK: if (ser_in == IDLE_LEVEL) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A new drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                          overflow <= 1'b0;
    else if (push && fifo_full && !pop)   overflow <= 1'b1;
    else if (clr_err)                     overflow <= 1'b0;
  end

  rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .push      (push),
    .push_data (shift),
    .pop       (pop),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
